// File: rtl/la_pwrseq.sv
// la_pwrseq: power-switch sequencer for a switched domain, living in the always-on domain.
//
// Power-up releases the switch sleep stages one at a time, from sleep[0] up to sleep[N-1],
// to limit inrush current. It then waits for power-good, drops isolation and finally
// releases the domain reset. Power-down runs the same steps in reverse order. A power-good
// fault forces the domain to its safe state and raises a sticky err.
//
// Parameters
//   N     number of switch stages
//   DW    width of delay
//   TW    width of timeout
//   PROP  implementation property string
//
// Ports
//   clk      in   clock
//   nreset   in   synchronous active-low reset
//   req      in   1 = domain requested on, 0 = requested off
//   delay    in   extra cycles between stage steps (step period = delay+1)
//   timeout  in   power-good wait limit, cycles
//   ack      in   power-good from the last switch stage (already synchronous)
//   sleep    out  per-stage switch sleep, 1 = switch off
//   iso      out  1 = domain outputs isolated
//   dnreset  out  domain reset, active-low
//   on       out  domain fully up
//   busy     out  sequence in progress
//   err      out  power-good fault (sticky while req=1)

module la_pwrseq #(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned TW   = 12,
    parameter string       PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          req,
    input  logic [DW-1:0] delay,
    input  logic [TW-1:0] timeout,
    input  logic          ack,
    output logic [N-1:0]  sleep,
    output logic          iso,
    output logic          dnreset,
    output logic          on,
    output logic          busy,
    output logic          err
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [3:0] {
        st_off,
        st_up,
        st_wack,
        st_isorel,
        st_rstrel,
        st_on,
        st_dnrst,
        st_dniso,
        st_dn,
        st_fault
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  sleep_q, sleep_d;
    logic          iso_q, iso_d;
    logic          dnreset_q, dnreset_d;
    logic          on_q, on_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;

    // A comparison with >= makes the step counter saturate at delay. This keeps the
    // timing sane if delay is lowered in the middle of a sequence.
    logic step_due;
    assign step_due = (cnt_q >= delay);

    // PROP carries no behaviour in this implementation.
    logic unused_prop;
    assign unused_prop = (PROP != "");

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= st_off;
            sleep_q   <= '1;
            iso_q     <= 1'b1;
            dnreset_q <= 1'b0;
            on_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            sleep_q   <= sleep_d;
            iso_q     <= iso_d;
            dnreset_q <= dnreset_d;
            on_q      <= on_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sleep_d   = sleep_q;
        iso_d     = iso_q;
        dnreset_d = dnreset_q;
        on_d      = on_q;
        busy_d    = busy_q;
        err_d     = err_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;

        case (state_q)
            st_off: begin
                err_d = 1'b0;
                if (req) begin
                    state_d = st_up;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end

            st_up: begin
                // Stage 0 is released on the first edge in UP. Each later stage waits
                // delay+1 cycles after the previous one.
                if ((idx_q == '0) || step_due) begin
                    sleep_d[idx_q] = 1'b0;
                    busy_d         = 1'b1;
                    cnt_d          = '0;
                    if (idx_q == IW'(N - 1)) begin
                        state_d = st_wack;
                        timer_d = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end

            st_wack: begin
                // The timer is compared before it is incremented, so it cannot wrap.
                if (ack) begin
                    state_d = st_isorel;
                    iso_d   = 1'b0;
                end else if (timer_q == timeout) begin
                    state_d = st_fault;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            st_isorel: begin
                state_d   = st_rstrel;
                dnreset_d = 1'b1;
            end

            st_rstrel: begin
                state_d = st_on;
                on_d    = 1'b1;
                busy_d  = 1'b0;
            end

            st_on: begin
                // Losing power-good takes priority over a power-down request.
                if (!ack) begin
                    state_d = st_fault;
                    on_d    = 1'b0;
                end else if (!req) begin
                    state_d   = st_dnrst;
                    on_d      = 1'b0;
                    dnreset_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            st_dnrst: begin
                state_d = st_dniso;
                iso_d   = 1'b1;
            end

            st_dniso: begin
                state_d          = st_dn;
                sleep_d[N-1]     = 1'b1;
                idx_d            = IW'(N - 2);
                cnt_d            = '0;
            end

            st_dn: begin
                // Once the first stage is back in sleep, leave on the following edge.
                if (sleep_q[0]) begin
                    state_d = st_off;
                    busy_d  = 1'b0;
                end else if (step_due) begin
                    sleep_d[idx_q] = 1'b1;
                    cnt_d          = '0;
                    if (idx_q != '0) begin
                        idx_d = idx_q - IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end

            st_fault: begin
                sleep_d   = '1;
                iso_d     = 1'b1;
                dnreset_d = 1'b0;
                on_d      = 1'b0;
                busy_d    = 1'b0;
                err_d     = req;
                if (!req) begin
                    state_d = st_off;
                end
            end

            default: begin
                state_d = st_off;
            end
        endcase
    end

    assign sleep   = sleep_q;
    assign iso     = iso_q;
    assign dnreset = dnreset_q;
    assign on      = on_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_la_pwrseq.sv
module tb_la_pwrseq;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TW = 12;

    // Expected output vector: {sleep[3:0], iso, dnreset, on, busy, err}
    localparam logic [8:0] OFFV  = 9'b1111_1_0_0_0_0;
    localparam logic [8:0] FAULTV = 9'b1111_1_0_0_0_1;

    logic          clk = 1'b0;
    logic          nreset;
    logic          req;
    logic [DW-1:0] delay;
    logic [TW-1:0] timeout;
    logic          ack;
    logic [N-1:0]  sleep;
    logic          iso;
    logic          dnreset;
    logic          on;
    logic          busy;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [8:0] v;
    } exp_t;

    exp_t sb[$];

    la_pwrseq #(
        .N   (N),
        .DW  (DW),
        .TW  (TW),
        .PROP("DEFAULT")
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .req    (req),
        .delay  (delay),
        .timeout(timeout),
        .ack    (ack),
        .sleep  (sleep),
        .iso    (iso),
        .dnreset(dnreset),
        .on     (on),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Expected outputs e edges after the edge that samples req=1 in OFF.
    function automatic logic [8:0] up_exp(int e, int d);
        int         c;
        int         last;
        logic [3:0] ones;
        logic [3:0] s;
        ones = 4'b1111;
        c    = (e < 1) ? 0 : ((e - 1) / (d + 1) + 1);
        if (c > 4) c = 4;
        s    = ones << c;
        last = 1 + 3 * (d + 1);
        return {s, 1'(e <= last), 1'(e >= last + 2), 1'(e >= last + 3),
                1'(e >= 1 && e < last + 3), 1'b0};
    endfunction

    // Expected outputs at edge e of power-down, where edge 1 samples req=0 in ON.
    function automatic logic [8:0] dn_exp(int e, int d);
        int         c;
        int         last;
        logic [3:0] ones;
        logic [3:0] s;
        ones = 4'b1111;
        c    = (e < 3) ? 0 : ((e - 3) / (d + 1) + 1);
        if (c > 4) c = 4;
        s    = ~(ones >> c);
        last = 3 + 3 * (d + 1);
        return {s, 1'(e >= 2), 1'b0, 1'b0, 1'(e <= last), 1'b0};
    endfunction

    task automatic push(input string tag, input logic [8:0] v);
        exp_t x;
        x.tag = tag;
        x.v   = v;
        sb.push_back(x);
    endtask

    task automatic tick();
        exp_t       x;
        logic [8:0] obs;
        @(posedge clk);
        #1;
        obs = {sleep, iso, dnreset, on, busy, err};
        n_checks++;
        assert (sb.size() != 0)
        else begin
            n_fail++;
            $error("FAIL sb_empty: observed %b with no expected entry", obs);
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            n_checks++;
            assert (obs === x.v)
            else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", x.tag, obs, x.v);
            end
        end
        n_checks++;
        assert (!(|sleep) || iso)
        else begin
            n_fail++;
            $error("FAIL inv_iso: sleep=%b iso=%b expected iso=1", sleep, iso);
        end
        n_checks++;
        assert (!(iso && dnreset))
        else begin
            n_fail++;
            $error("FAIL inv_rst: iso=%b dnreset=%b expected dnreset=0", iso, dnreset);
        end
    endtask

    task automatic run_up(input string tag, input int d, input int last_e);
        for (int e = 0; e <= last_e; e++) begin
            push(tag, up_exp(e, d));
            tick();
        end
    endtask

    task automatic run_dn(input string tag, input int d, input int last_e);
        for (int e = 1; e <= last_e; e++) begin
            push(tag, dn_exp(e, d));
            tick();
        end
    endtask

    initial begin
        nreset  = 1'b0;
        req     = 1'b0;
        ack     = 1'b1;
        delay   = '0;
        timeout = TW'(20);
        push("reset", OFFV);
        tick();
        push("reset", OFFV);
        tick();
        nreset = 1'b1;
        push("idle", OFFV);
        tick();

        // Power-up with delay=0, then hold ON for one extra edge.
        req = 1'b1;
        run_up("up_d0", 0, 8);

        // Power-down with delay=0, then stay OFF.
        req = 1'b0;
        run_dn("dn_d0", 0, 7);
        push("dn_idle", OFFV);
        tick();

        // Power-up with delay=3: on=1 at edge 16.
        delay = DW'(3);
        req   = 1'b1;
        run_up("up_d3", 3, 17);

        // Power-down with delay=1.
        delay = DW'(1);
        req   = 1'b0;
        run_dn("dn_d1", 1, 10);

        // req pulsed low during UP has no effect; ON keeps req=1.
        delay = '0;
        req   = 1'b1;
        push("pulse", up_exp(0, 0));
        tick();
        push("pulse", up_exp(1, 0));
        tick();
        req = 1'b0;
        push("pulse", up_exp(2, 0));
        tick();
        req = 1'b1;
        for (int e = 3; e <= 9; e++) begin
            push("pulse", up_exp(e, 0));
            tick();
        end
        req = 1'b0;
        run_dn("pulse_dn", 0, 7);

        // Power-good timeout: WACK is entered at edge 4 and err=1 follows 12 edges later.
        ack     = 1'b0;
        timeout = TW'(10);
        req     = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            push("to10_up", up_exp(e, 0));
            tick();
        end
        for (int e = 5; e <= 15; e++) begin
            push("to10_wack", up_exp(4, 0));
            tick();
        end
        push("to10_fault", FAULTV);
        tick();
        push("to10_sticky", FAULTV);
        tick();
        req = 1'b0;
        push("to10_clear", OFFV);
        tick();
        push("to10_off", OFFV);
        tick();

        // timeout=0 faults at the first WACK edge.
        timeout = '0;
        req     = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            push("to0", up_exp(e < 5 ? e : 4, 0));
            tick();
        end
        push("to0_fault", FAULTV);
        tick();
        req = 1'b0;
        push("to0_clear", OFFV);
        tick();

        // Synchronous reset at edge 3 of UP aborts immediately.
        ack     = 1'b1;
        timeout = TW'(20);
        req     = 1'b1;
        for (int e = 0; e <= 2; e++) begin
            push("rst_up", up_exp(e, 0));
            tick();
        end
        nreset = 1'b0;
        push("rst_abort", OFFV);
        tick();
        nreset = 1'b1;
        run_up("rst_reup", 0, 8);

        // Loss of power-good while ON.
        ack = 1'b0;
        push("ackloss", 9'b0000_0_1_0_0_0);
        tick();
        push("ackloss_fault", FAULTV);
        tick();
        req = 1'b0;
        ack = 1'b1;
        push("ackloss_clear", OFFV);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
